neda_fir_ctrl: RTL and testbench
================================

NEDA_FIR_CTRL -- requirements
Module: neda_fir_ctrl

Interface
REQ-001 SHALL have parameter SUPPRESS_WARMUP, default 1: 1 drops outputs until the delay line holds 8 frame samples; 0 emits every output, with unfilled taps reading 0.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clr  input  1  synchronous soft clear.
REQ-005 SHALL have ports s_valid  input  1, s_ready  output  1, s_data  input  8 (signed sample), s_last  input  1 (last sample of frame).
REQ-006 SHALL have port neda_x  output  64  tap bus to the external combinational NEDA datapath; [7:0] holds the newest sample, [63:56] the oldest.
REQ-007 SHALL have port neda_y  input  24  signed datapath result for the current neda_x.
REQ-008 SHALL have ports m_valid  output  1, m_ready  input  1, m_data  output  24, m_last  output  1.
REQ-009 SHALL have port busy  output  1, equal to v1 | m_valid | (fill_cnt != 0).

Function
REQ-010 SHALL implement a 2-stage pipeline.
  - Stage 1: the delay line, driven directly onto neda_x, plus flag v1 and flag l1 (last).
  - Stage 2: output register m_data/m_last/m_valid.
REQ-011 Stage 2 SHALL advance when adv2 = !m_valid | m_ready.
REQ-012 s_ready SHALL equal !v1 | adv2; a transfer occurs when s_valid & s_ready.
REQ-013 On transfer, the delay line SHALL shift: neda_x <= {neda_x[55:0], s_data}; v1 <= 1; l1 <= s_last.
  - If v1 & adv2 and no transfer, v1 <= 0.
REQ-014 When v1 & adv2 and the stage-1 sample is not suppressed, stage 2 SHALL load m_data <= neda_y, m_last <= l1, m_valid <= 1.
  - If stage 2 advances with nothing loaded, m_valid <= 0.
REQ-015 Latency SHALL be accept at edge N -> m_valid high after edge N+1; throughput is 1 sample/cycle with m_ready held high.
REQ-016 m_data, m_last and m_valid SHALL stay stable while m_valid & !m_ready.
REQ-017 fill_cnt (0..8) SHALL count accepted samples per frame, incrementing on each transfer and saturating at 8.
  - Frame FSM: IDLE (cnt=0), FILL (1..7), RUN (8).
REQ-018 With SUPPRESS_WARMUP=1, a stage-1 sample accepted while fill_cnt became <8 SHALL be dropped, not loaded to stage 2, unless l1=1.
  - l1=1 is always emitted so framing is preserved.
  - A dropped sample still clears v1 when it leaves stage 1.
REQ-019 When a stage-1 sample with l1=1 leaves stage 1, the delay line SHALL be zeroed and fill_cnt reset to 0, returning to IDLE.
  - If a transfer occurs in the same cycle, the line becomes {56'b0, s_data} and fill_cnt = 1.
REQ-020 Sum widths and arithmetic SHALL belong to the datapath; this block does no arithmetic on neda_y and passes 24 bits unchanged.
REQ-021 clr SHALL take priority over all other activity.
  - Next cycle: v1=0, l1=0, m_valid=0, m_last=0, neda_x=0, fill_cnt=0.
  - s_data presented with clr high is not accepted; s_ready is forced to 0 while clr=1.

Reset
REQ-022 While rst_n=0, the block SHALL hold neda_x=0, v1=0, l1=0, m_valid=0, m_data=0, m_last=0, fill_cnt=0 (IDLE), s_ready=0 and busy=0.
REQ-023 Reset assertion mid-frame SHALL discard all in-flight samples immediately, with no output emitted for them.
REQ-024 After rst_n deasserts, s_ready SHALL be 1 from the first clock edge.

Verification (bench attaches the real NEDA datapath; coefficients 5,17,43,63,63,43,17,5)
REQ-025 Impulse, SUPPRESS_WARMUP=0: samples 1,0,0,0,0,0,0,0 (last on 8th), m_ready=1.
  - Required m_data: 5,17,43,63,63,43,17,5.
  - m_last only on the 8th output.
  - Delay line reads 0 afterwards.
REQ-026 Warm-up drop, SUPPRESS_WARMUP=1: 10 samples of +1.
  - Exactly 3 outputs, each 256 (24'h000100).
  - With last on the 10th sample, the 3rd output has m_last=1.
REQ-027 Negative full scale: 8 samples of -128 (8'h80).
  - Final output 24'hFF8000 (-32768).
REQ-028 Backpressure: hold m_ready=0 for 5 cycles with stages full.
  - s_ready=0.
  - m_data stable.
  - On release, outputs resume in order with none lost or duplicated.
REQ-029 Frame boundary: the last sample of frame A leaves stage 1 while the first sample 7 of frame B is accepted.
  - The next neda_x is 64'h0000_0000_0000_0007.
  - fill_cnt = 1.
REQ-030 clr and reset mid-frame: clr at fill_cnt=5 with m_valid=1.
  - Next cycle: m_valid=0, busy=0, neda_x=0.
  - Repeat the same check with an asynchronous rst_n pulse between edges; outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/neda_fir_ctrl_if.sv
// Stream handshake bundle for the NEDA FIR controller: sample input and result output.
interface neda_fir_ctrl_if;
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned RESULT_W = 24;

    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_data;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic [RESULT_W-1:0] m_data;
    logic                m_last;

    // Producer/consumer side (testbench or surrounding fabric)
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    // Controller side
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/neda_fir_ctrl.sv
// Control and delay line for an 8-tap NEDA FIR: feeds the external datapath
// through neda_x and registers its result, with per-frame warm-up handling.
module neda_fir_ctrl #(
    parameter bit SUPPRESS_WARMUP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    neda_fir_ctrl_if.slave       bus,
    output logic [63:0]          neda_x,
    input  logic [23:0]          neda_y,
    output logic                 busy
);
    localparam int unsigned TAPS     = 8;
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned LINE_W   = TAPS * SAMPLE_W;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(TAPS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               v1;
    logic               l1;
    logic               w1;
    logic [CNT_W-1:0]   fill_cnt;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [LINE_W-1:0]  line_base;
    logic [LINE_W-1:0]  line_nxt;
    logic               adv2;
    logic               ready_c;
    logic               xfer;
    logic               leave1;
    logic               drop;
    logic               emit;
    logic               frame_end;

    // Handshake decode and next delay-line / fill-count values
    always_comb begin
        adv2      = !bus.m_valid | bus.m_ready;
        ready_c   = rst_n & !clr & (!v1 | adv2);
        xfer      = bus.s_valid & ready_c;
        leave1    = v1 & adv2;
        drop      = SUPPRESS_WARMUP & w1 & !l1;
        emit      = leave1 & !drop;
        frame_end = leave1 & l1;
        line_base = frame_end ? '0 : neda_x;
        cnt_base  = frame_end ? '0 : fill_cnt;
        line_nxt  = line_base;
        cnt_nxt   = cnt_base;
        if (xfer) begin
            line_nxt = {line_base[LINE_W-SAMPLE_W-1:0], bus.s_data};
            cnt_nxt  = (cnt_base == FILL_MAX) ? FILL_MAX : cnt_base + CNT_W'(1);
        end
        if (cnt_nxt == '0) begin
            state_nxt = ST_IDLE;
        end else if (cnt_nxt == FILL_MAX) begin
            state_nxt = ST_RUN;
        end else begin
            state_nxt = ST_FILL;
        end
    end

    assign bus.s_ready = ready_c;
    assign busy        = v1 | bus.m_valid | (state != ST_IDLE);

    // Stage 1 (delay line, frame FSM) and stage 2 (result register)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neda_x      <= '0;
            fill_cnt    <= '0;
            state       <= ST_IDLE;
            v1          <= 1'b0;
            l1          <= 1'b0;
            w1          <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
        end else if (clr) begin
            neda_x      <= '0;
            fill_cnt    <= '0;
            state       <= ST_IDLE;
            v1          <= 1'b0;
            l1          <= 1'b0;
            w1          <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
        end else begin
            neda_x   <= line_nxt;
            fill_cnt <= cnt_nxt;
            state    <= state_nxt;
            if (xfer) begin
                v1 <= 1'b1;
                l1 <= bus.s_last;
                // Sample taken before the line was full is a warm-up sample
                w1 <= (cnt_nxt < FILL_MAX);
            end else if (leave1) begin
                v1 <= 1'b0;
                l1 <= 1'b0;
                w1 <= 1'b0;
            end
            if (adv2) begin
                bus.m_valid <= emit;
                bus.m_last  <= emit & l1;
                if (emit) begin
                    bus.m_data <= neda_y;
                end
            end
        end
    end
endmodule

// File: tb/tb_neda_fir_ctrl.sv
// Directed bench for neda_fir_ctrl with a behavioural NEDA datapath attached.
module tb_neda_fir_ctrl;
    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [63:0] nx0;
    logic [63:0] nx1;
    logic [23:0] ny0;
    logic [23:0] ny1;
    logic        busy0;
    logic        busy1;
    int          errors;
    int          checks;
    logic [24:0] q0[$];
    logic [24:0] q1[$];

    neda_fir_ctrl_if if0();
    neda_fir_ctrl_if if1();

    neda_fir_ctrl #(.SUPPRESS_WARMUP(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0),
        .neda_x(nx0), .neda_y(ny0), .busy(busy0)
    );

    neda_fir_ctrl u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1),
        .neda_x(nx1), .neda_y(ny1), .busy(busy1)
    );

    // Reference datapath: coefficients 5,17,43,63,63,43,17,5, tap 0 = newest
    function automatic logic [23:0] fir(input logic [63:0] x);
        int acc;
        int c [8];
        logic signed [7:0] s;
        c = '{5, 17, 43, 63, 63, 43, 17, 5};
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            s = x[8*k +: 8];
            acc += c[k] * int'(s);
        end
        return 24'(acc);
    endfunction

    assign ny0 = fir(nx0);
    assign ny1 = fir(nx1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if0.m_valid && if0.m_ready) q0.push_back({if0.m_last, if0.m_data});
        if (if1.m_valid && if1.m_ready) q1.push_back({if1.m_last, if1.m_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one sample to DUT sel, wait (bounded) for acceptance
    task automatic push(input bit sel, input logic [7:0] d, input logic l);
        int n;
        if (sel) begin
            if1.s_valid = 1'b1; if1.s_data = d; if1.s_last = l;
        end else begin
            if0.s_valid = 1'b1; if0.s_data = d; if0.s_last = l;
        end
        #1;
        n = 0;
        while (!(sel ? if1.s_ready : if0.s_ready) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("push_accept", 64'(n < 20), 64'(1));
        @(posedge clk);
        @(negedge clk);
        if (sel) if1.s_valid = 1'b0;
        else     if0.s_valid = 1'b0;
    endtask

    initial begin
        logic [23:0] imp_exp [8];
        int qn;
        imp_exp = '{24'd5, 24'd17, 24'd43, 24'd63, 24'd63, 24'd43, 24'd17, 24'd5};
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        if0.s_valid = 1'b0; if0.s_data = '0; if0.s_last = 1'b0; if0.m_ready = 1'b1;
        if1.s_valid = 1'b0; if1.s_data = '0; if1.s_last = 1'b0; if1.m_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_ready", 64'(if1.s_ready), 64'(0));
        chk("rst_busy", 64'(busy1), 64'(0));
        chk("rst_m_valid", 64'(if1.m_valid), 64'(0));
        chk("rst_m_data", 64'(if1.m_data), 64'(0));
        chk("rst_m_last", 64'(if1.m_last), 64'(0));
        chk("rst_neda_x", nx1, 64'(0));
        chk("rst_fill", 64'(u_dut1.fill_cnt), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("post_rst_s_ready0", 64'(if0.s_ready), 64'(1));
        chk("post_rst_s_ready1", 64'(if1.s_ready), 64'(1));

        // Impulse response without warm-up suppression
        push(1'b0, 8'd1, 1'b0);
        for (int i = 0; i < 6; i++) push(1'b0, 8'd0, 1'b0);
        push(1'b0, 8'd0, 1'b1);
        repeat (4) @(negedge clk);
        chk("imp_count", 64'(q0.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            chk("imp_data", 64'(q0[i][23:0]), 64'(imp_exp[i]));
            chk("imp_last", 64'(q0[i][24]), 64'(i == 7));
        end
        chk("imp_line_zero", nx0, 64'(0));

        // Warm-up drop: 10 samples of +1, last on the 10th
        q1.delete();
        for (int i = 1; i <= 10; i++) push(1'b1, 8'd1, i == 10);
        repeat (4) @(negedge clk);
        chk("warm_count", 64'(q1.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            chk("warm_data", 64'(q1[i][23:0]), 64'(24'h000100));
            chk("warm_last", 64'(q1[i][24]), 64'(i == 2));
        end

        // Negative full scale
        q1.delete();
        for (int i = 1; i <= 8; i++) push(1'b1, 8'h80, i == 8);
        repeat (4) @(negedge clk);
        chk("negfs_count", 64'(q1.size()), 64'(1));
        chk("negfs_data", 64'(q1[0][23:0]), 64'(24'hFF8000));
        chk("negfs_last", 64'(q1[0][24]), 64'(1));

        // Backpressure with both stages full
        q1.delete();
        for (int i = 0; i < 7; i++) push(1'b1, 8'd1, 1'b0);
        if1.m_ready = 1'b0;
        push(1'b1, 8'd2, 1'b0);
        push(1'b1, 8'd3, 1'b0);
        if1.s_valid = 1'b1; if1.s_data = 8'd4; if1.s_last = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_s_ready", 64'(if1.s_ready), 64'(0));
            chk("bp_m_valid", 64'(if1.m_valid), 64'(1));
            chk("bp_m_data", 64'(if1.m_data), 64'(261));
            @(negedge clk); #1;
        end
        if1.m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if1.s_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_count", 64'(q1.size()), 64'(3));
        chk("bp_out0", 64'(q1[0]), 64'({1'b0, 24'd261}));
        chk("bp_out1", 64'(q1[1]), 64'({1'b0, 24'd283}));
        chk("bp_out2", 64'(q1[2]), 64'({1'b1, 24'd348}));

        // Frame boundary: last of A leaves stage 1 as first of B enters
        q1.delete();
        push(1'b1, 8'd9, 1'b0);
        push(1'b1, 8'd9, 1'b0);
        push(1'b1, 8'd9, 1'b1);
        push(1'b1, 8'd7, 1'b0);
        chk("fb_neda_x", nx1, 64'h0000_0000_0000_0007);
        chk("fb_fill", 64'(u_dut1.fill_cnt), 64'(1));
        repeat (3) @(negedge clk);
        chk("fb_count", 64'(q1.size()), 64'(1));
        chk("fb_out", 64'(q1[0]), 64'({1'b1, 24'd585}));

        // Soft clear mid-frame
        for (int i = 1; i <= 5; i++) push(1'b0, 8'(i), 1'b0);
        chk("clr_pre_fill", 64'(u_dut0.fill_cnt), 64'(5));
        chk("clr_pre_m_valid", 64'(if0.m_valid), 64'(1));
        clr = 1'b1;
        if0.s_valid = 1'b1; if0.s_data = 8'h55; if0.s_last = 1'b0;
        #1;
        chk("clr_s_ready0", 64'(if0.s_ready), 64'(0));
        chk("clr_s_ready1", 64'(if1.s_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        if0.s_valid = 1'b0;
        #1;
        chk("clr_m_valid", 64'(if0.m_valid), 64'(0));
        chk("clr_busy", 64'(busy0), 64'(0));
        chk("clr_neda_x", nx0, 64'(0));
        chk("clr_fill", 64'(u_dut0.fill_cnt), 64'(0));

        // Asynchronous reset pulse between clock edges
        for (int i = 1; i <= 5; i++) push(1'b0, 8'(i + 16), 1'b0);
        chk("ar_pre_m_valid", 64'(if0.m_valid), 64'(1));
        chk("ar_pre_fill", 64'(u_dut0.fill_cnt), 64'(5));
        qn = q0.size();
        #1 rst_n = 1'b0;
        #1;
        chk("ar_m_valid", 64'(if0.m_valid), 64'(0));
        chk("ar_busy", 64'(busy0), 64'(0));
        chk("ar_neda_x", nx0, 64'(0));
        chk("ar_fill", 64'(u_dut0.fill_cnt), 64'(0));
        chk("ar_s_ready", 64'(if0.s_ready), 64'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ar_post_s_ready", 64'(if0.s_ready), 64'(1));
        repeat (4) @(negedge clk);
        chk("ar_no_output", 64'(q0.size()), 64'(qn));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
